// File: rtl/param_fifo.sv
// Parametrised single-clock circular FIFO with selectable standard or
// first-word-fall-through read, almost-full/almost-empty flags, level
// output, overflow/underflow pulses and a synchronous flush.
module param_fifo #(
    parameter int DATA      = 8,
    parameter int ADDR      = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [DATA-1:0] write_data,
    input  logic            write_req,
    input  logic            read_req,
    output logic [DATA-1:0] read_data,
    output logic            read_data_valid,
    output logic            fifo_empty,
    output logic            fifo_full,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [ADDR:0]   level,
    output logic            fifo_of,
    output logic            fifo_uf
);

    localparam int DEPTH = 2 ** ADDR;
    localparam logic [ADDR:0] DEPTH_L  = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR:0] AFULL_L  = (ADDR + 1)'(AFULL_TH);
    localparam logic [ADDR:0] AEMPTY_L = (ADDR + 1)'(AEMPTY_TH);

    logic [DATA-1:0] mem [DEPTH];
    logic [ADDR-1:0] w_ptr_reg;
    logic [ADDR-1:0] r_ptr_reg;
    logic [ADDR:0]   level_reg;
    logic [ADDR:0]   level_next;
    logic            of_reg;
    logic            uf_reg;
    logic            wr_acc;
    logic            rd_acc;

    // Flags decode only from the registered level, never from the inputs.
    assign fifo_empty   = (level_reg == '0);
    assign fifo_full    = (level_reg == DEPTH_L);
    assign almost_full  = (level_reg >= AFULL_L);
    assign almost_empty = (level_reg <= AEMPTY_L);
    assign level        = level_reg;
    assign fifo_of      = of_reg;
    assign fifo_uf      = uf_reg;

    // Accepts are suppressed during reset and flush so memory is never
    // written and pointers never move in those cycles.
    assign wr_acc = rst && !flush && write_req && !fifo_full;
    assign rd_acc = rst && !flush && read_req && !fifo_empty;

    // Occupancy computed in ADDR+1 bits; accept gating prevents wrap.
    assign level_next = level_reg + {{ADDR{1'b0}}, wr_acc} - {{ADDR{1'b0}}, rd_acc};

    // Pointer, level and error-pulse state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_ptr_reg <= '0;
            r_ptr_reg <= '0;
            level_reg <= '0;
            of_reg    <= 1'b0;
            uf_reg    <= 1'b0;
        end else if (flush) begin
            w_ptr_reg <= '0;
            r_ptr_reg <= '0;
            level_reg <= '0;
            of_reg    <= 1'b0;
            uf_reg    <= 1'b0;
        end else begin
            if (wr_acc) w_ptr_reg <= w_ptr_reg + 1'b1;
            if (rd_acc) r_ptr_reg <= r_ptr_reg + 1'b1;
            level_reg <= level_next;
            of_reg    <= write_req && fifo_full;
            uf_reg    <= read_req && fifo_empty;
        end
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[w_ptr_reg] <= write_data;
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA-1:0] read_data_reg;
            logic            read_valid_reg;

            // Registered read: data lands one cycle after an accepted pop.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    read_data_reg  <= '0;
                    read_valid_reg <= 1'b0;
                end else if (flush) begin
                    read_valid_reg <= 1'b0;
                end else begin
                    read_valid_reg <= rd_acc;
                    if (rd_acc) read_data_reg <= mem[r_ptr_reg];
                end
            end

            assign read_data       = read_data_reg;
            assign read_data_valid = read_valid_reg;
        end else begin : g_fwft
            // Head word is presented continuously; read_req acknowledges it.
            assign read_data       = mem[r_ptr_reg];
            assign read_data_valid = !fifo_empty;
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a standard-mode and an FWFT-mode instance share one
// stimulus stream and are compared every cycle against a queue-based model,
// with directed scenarios pinned by literal expectations.
module tb_param_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] wd = 8'h00;

    logic [7:0] s_data, f_data;
    logic       s_valid, f_valid;
    logic       s_empty, f_empty, s_full, f_full;
    logic       s_af, f_af, s_ae, f_ae;
    logic [4:0] s_level, f_level;
    logic       s_of, f_of, s_uf, f_uf;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    param_fifo #(.DATA(8), .ADDR(4), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .write_data(wd), .write_req(wr),
        .read_req(rd), .read_data(s_data), .read_data_valid(s_valid),
        .fifo_empty(s_empty), .fifo_full(s_full), .almost_full(s_af),
        .almost_empty(s_ae), .level(s_level), .fifo_of(s_of), .fifo_uf(s_uf)
    );

    param_fifo #(.DATA(8), .ADDR(4), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .write_data(wd), .write_req(wr),
        .read_req(rd), .read_data(f_data), .read_data_valid(f_valid),
        .fifo_empty(f_empty), .fifo_full(f_full), .almost_full(f_af),
        .almost_empty(f_ae), .level(f_level), .fifo_of(f_of), .fifo_uf(f_uf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: contents as a queue, outputs derived from its size.
    logic [7:0] q[$];
    logic [7:0] m_data = 8'h00;
    bit         m_valid = 1'b0;
    bit         m_of = 1'b0;
    bit         m_uf = 1'b0;
    bit         m_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_of    = 1'b0;
            m_uf    = 1'b0;
            m_ok    = 1'b1;
        end else if (flush) begin
            q.delete();
            m_valid = 1'b0;
            m_of    = 1'b0;
            m_uf    = 1'b0;
        end else begin
            bit full_now, empty_now;
            full_now  = (q.size() == DEPTH);
            empty_now = (q.size() == 0);
            m_of = wr && full_now;
            m_uf = rd && empty_now;
            if (rd && !empty_now) begin
                m_data  = q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (wr && !full_now) q.push_back(wd);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            int lvl;
            lvl = q.size();
            check("s_level", s_level, lvl);
            check("f_level", f_level, lvl);
            check("s_empty", s_empty, lvl == 0);
            check("f_empty", f_empty, lvl == 0);
            check("s_full", s_full, lvl == DEPTH);
            check("f_full", f_full, lvl == DEPTH);
            check("s_afull", s_af, lvl >= AF);
            check("f_afull", f_af, lvl >= AF);
            check("s_aempty", s_ae, lvl <= AE);
            check("f_aempty", f_ae, lvl <= AE);
            check("s_of", s_of, m_of);
            check("f_of", f_of, m_of);
            check("s_uf", s_uf, m_uf);
            check("f_uf", f_uf, m_uf);
            check("s_valid", s_valid, m_valid);
            check("s_data", s_data, m_data);
            check("f_valid", f_valid, lvl != 0);
            if (lvl != 0) check("f_data", f_data, q[0]);
        end
    end

    task automatic step(input bit w, input bit r, input bit f, input logic [7:0] d, input bit rs);
        wr = w; rd = r; flush = f; wd = d; rst = rs;
        @(posedge clk);
        #1;
        cyc++;
        $display("[TB] cyc %0d rst=%0b fl=%0b wr=%0b rd=%0b wd=%02h -> lvl=%0d sv=%0b sd=%02h fv=%0b fd=%02h",
                 cyc, rs, f, w, r, d, s_level, s_valid, s_data, f_valid, f_data);
    endtask

    initial begin
        // 1: reset then fill
        step(0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        check("rst_level", s_level, 0);
        check("rst_empty", s_empty, 1);
        check("rst_aempty", s_ae, 1);
        check("rst_full", s_full, 0);
        check("rst_afull", s_af, 0);
        check("rst_valid", s_valid, 0);
        check("rst_data", s_data, 0);
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, 8'(i), 1);
            if (i == 11) check("afull_at11", s_af, 0);
            if (i == 12) check("afull_at12", s_af, 1);
        end
        check("full_16", s_full, 1);
        check("level_16", s_level, 16);
        step(1, 0, 0, 8'hEE, 1);
        check("of_pulse", s_of, 1);
        check("of_level", s_level, 16);
        step(0, 0, 0, 8'h00, 1);
        check("of_clear", s_of, 0);

        // 2: drain in order
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, 8'h00, 1);
            check("drain_data", s_data, i);
            check("drain_valid", s_valid, 1);
        end
        check("drain_empty", s_empty, 1);
        step(0, 1, 0, 8'h00, 1);
        check("uf_pulse", s_uf, 1);
        check("uf_valid", s_valid, 0);
        step(0, 0, 0, 8'h00, 1);
        check("uf_clear", s_uf, 0);

        // 3: level 5 with simultaneous read/write across pointer wrap
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h20 + i), 1);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 8'(8'h30 + i), 1);
            check("rw_level", s_level, 5);
        end

        // 4: full with read+write, then empty with read+write
        for (int i = 0; i < 11; i++) step(1, 0, 0, 8'(8'h50 + i), 1);
        check("fill_full", s_full, 1);
        step(1, 1, 0, 8'h77, 1);
        check("full_rw_of", s_of, 1);
        check("full_rw_level", s_level, 15);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 8'h00, 1);
        check("empty_again", s_empty, 1);
        step(1, 1, 0, 8'h66, 1);
        check("empty_rw_uf", s_uf, 1);
        check("empty_rw_level", s_level, 1);

        // 5: flush at level 9, then mid-stream reset
        for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(8'h90 + i), 1);
        check("level_9", s_level, 9);
        step(1, 1, 1, 8'hFF, 1);
        check("flush_level", s_level, 0);
        check("flush_empty", s_empty, 1);
        check("flush_of", s_of, 0);
        check("flush_uf", s_uf, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'hB0 + i), 1);
        step(0, 1, 0, 8'h00, 1);
        step(1, 1, 0, 8'hC0, 0);
        check("mrst_level", s_level, 0);
        check("mrst_valid", s_valid, 0);
        check("mrst_data", s_data, 0);
        check("mrst_empty", s_empty, 1);
        check("mrst_of", s_of, 0);

        // 6: FWFT presentation
        step(1, 0, 0, 8'hA5, 1);
        check("fwft_valid", f_valid, 1);
        check("fwft_data", f_data, 8'hA5);
        step(0, 1, 0, 8'h00, 1);
        check("fwft_empty", f_empty, 1);
        check("fwft_novalid", f_valid, 0);

        // Randomised phases with varying read/write pressure
        for (int p = 0; p < 16; p++) begin
            int pw, pr;
            pw = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     $urandom_range(0, 99) == 0, 8'($urandom_range(0, 255)),
                     $urandom_range(0, 199) != 0);
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
